// File: rtl/burst_to_lite_sipo_if.sv
// Burst-side header/data channels plus the single-beat lite output channel.
// The slave side is the converter; the master side drives bursts and drains messages.
interface burst_to_lite_sipo_if #(
    parameter int unsigned header_width_p   = 64,
    parameter int unsigned in_data_width_p  = 64,
    parameter int unsigned out_data_width_p = 512
);
    logic [header_width_p-1:0]                  in_header;
    logic                                       in_header_v;
    logic                                       in_header_ready;
    logic [in_data_width_p-1:0]                 in_data;
    logic                                       in_data_v;
    logic                                       in_data_ready;
    logic [header_width_p+out_data_width_p-1:0] out_msg;
    logic                                       out_msg_v;
    logic                                       out_msg_ready;

    modport slave (
        input  in_header, in_header_v, in_data, in_data_v, out_msg_ready,
        output in_header_ready, in_data_ready, out_msg, out_msg_v
    );

    modport master (
        output in_header, in_header_v, in_data, in_data_v, out_msg_ready,
        input  in_header_ready, in_data_ready, out_msg, out_msg_v
    );
endinterface

// File: rtl/burst_to_lite_sipo.sv
// Collects a burst (header + narrow beats) into one wide {header, data} lite message.
// One-entry header buffer, burst-length register with handshake bypass, dynamic-length SIPO.
module burst_to_lite_sipo #(
    parameter int unsigned header_width_p   = 64,
    parameter int unsigned in_data_width_p  = 64,
    parameter int unsigned out_data_width_p = 512,
    parameter int unsigned size_lsb_p       = 0,
    parameter int unsigned msg_type_lsb_p   = 3,
    parameter int unsigned msg_type_width_p = 4,
    parameter logic [(1<<msg_type_width_p)-1:0] payload_mask_p = '0
) (
    input logic                clk_i,
    input logic                reset_i,
    burst_to_lite_sipo_if.slave bus
);
    localparam int unsigned W          = out_data_width_p / in_data_width_p;
    localparam int unsigned LW         = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned BEAT_BYTES = in_data_width_p / 8;

    logic                      hdr_full;
    logic [header_width_p-1:0] hdr_q;
    logic                      hdr_hs;
    logic                      out_hs;
    logic                      has_data;
    logic                      yumi;

    logic [2:0]    in_size;
    logic [31:0]   in_bytes;
    logic [31:0]   in_beats;
    logic [LW-1:0] inc;
    logic [LW-1:0] len_r;
    logic [LW-1:0] num;

    logic                              sipo_v;
    logic [LW-1:0]                     cnt;
    logic [LW-1:0]                     len_q;
    logic [LW-1:0]                     cur_len;
    logic                              beat_hs;
    logic [W-1:0][in_data_width_p-1:0] sipo_data;

    assign hdr_hs = bus.in_header_v & ~hdr_full;
    assign out_hs = bus.out_msg_v & bus.out_msg_ready;

    // Beats per burst; a full-width burst (W beats) wraps to 0 and still yields W beats below.
    assign in_size  = bus.in_header[size_lsb_p +: 3];
    assign in_bytes = 32'd1 << in_size;
    assign in_beats = in_bytes / BEAT_BYTES;
    assign inc      = (in_beats == 32'd0) ? LW'(1) : in_beats[LW-1:0];
    assign num      = hdr_hs ? inc : len_r;

    // Length is taken from num only on the first beat, then held in len_q for the rest.
    assign cur_len = (cnt == '0) ? num - LW'(1) : len_q;
    assign beat_hs = bus.in_data_v & ~sipo_v;

    assign has_data = payload_mask_p[hdr_q[msg_type_lsb_p +: msg_type_width_p]];
    assign yumi     = out_hs & has_data;

    assign bus.in_header_ready = ~hdr_full;
    assign bus.in_data_ready   = ~sipo_v;
    assign bus.out_msg_v       = hdr_full & (sipo_v | ~has_data);
    assign bus.out_msg         = {hdr_q, sipo_data};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hdr_full <= 1'b0;
            hdr_q    <= '0;
            len_r    <= '0;
            sipo_v   <= 1'b0;
            cnt      <= '0;
            len_q    <= '0;
        end else begin
            if (hdr_hs) begin
                hdr_full <= 1'b1;
                hdr_q    <= bus.in_header;
                len_r    <= inc;
            end else if (out_hs) begin
                hdr_full <= 1'b0;
            end

            if (beat_hs) begin
                if (cnt == '0) len_q <= cur_len;
                if (cnt == cur_len) begin
                    sipo_v <= 1'b1;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + LW'(1);
                end
            end else if (yumi) begin
                sipo_v <= 1'b0;
            end
        end
    end

    // Data slots are not reset: words not written by a burst keep their prior contents.
    always_ff @(posedge clk_i) begin
        if (beat_hs) sipo_data[cnt] <= bus.in_data;
    end
endmodule

// File: tb/tb_burst_to_lite_sipo.sv
// Directed + randomized bench for burst_to_lite_sipo against a slot-array / queue reference model.
module tb_burst_to_lite_sipo;
    localparam int H  = 64;
    localparam int IW = 64;
    localparam int OW = 512;
    localparam int W  = OW / IW;
    localparam int MW = H + OW;
    localparam logic [15:0] MASK = 16'h00F2;
    localparam logic [3:0]  T_WR = 4'd1;
    localparam logic [3:0]  T_RD = 4'd0;
    localparam int NRND = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;

    burst_to_lite_sipo_if #(.header_width_p(H), .in_data_width_p(IW), .out_data_width_p(OW)) bus ();

    burst_to_lite_sipo #(
        .header_width_p(H), .in_data_width_p(IW), .out_data_width_p(OW),
        .size_lsb_p(0), .msg_type_lsb_p(3), .msg_type_width_p(4), .payload_mask_p(MASK)
    ) dut (
        .clk_i(clk),
        .reset_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0][IW-1:0] model;
    logic [MW-1:0]        expq[$];

    task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [H-1:0] mkhdr(input logic [3:0] t, input logic [2:0] sz);
        logic [H-1:0] h;
        h      = {$urandom, $urandom};
        h[6:3] = t;
        h[2:0] = sz;
        return h;
    endfunction

    function automatic int nbeats(input logic [2:0] sz);
        int b;
        b = (1 << sz) / (IW / 8);
        return (b < 1) ? 1 : b;
    endfunction

    task automatic put_hdr(input logic [H-1:0] h);
        int n;
        n = 0;
        bus.in_header   = h;
        bus.in_header_v = 1'b1;
        while (!bus.in_header_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("hdr_timeout", MW'(0), MW'(1));
        tick();
        bus.in_header_v = 1'b0;
    endtask

    task automatic put_beat(input logic [IW-1:0] d, input int slot);
        int n;
        n = 0;
        bus.in_data   = d;
        bus.in_data_v = 1'b1;
        while (!bus.in_data_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("beat_timeout", MW'(0), MW'(1));
        tick();
        bus.in_data_v = 1'b0;
        model[slot]   = d;
    endtask

    task automatic put_both(input logic [H-1:0] h, input logic [IW-1:0] d);
        bus.in_header   = h;
        bus.in_header_v = 1'b1;
        bus.in_data     = d;
        bus.in_data_v   = 1'b1;
        chk("both_rdy", MW'({bus.in_header_ready, bus.in_data_ready}), MW'(2'b11));
        tick();
        bus.in_header_v = 1'b0;
        bus.in_data_v   = 1'b0;
        model[0]        = d;
    endtask

    task automatic take();
        bus.out_msg_ready = 1'b1;
        tick();
        bus.out_msg_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [H-1:0]  h, h2;
        logic [2:0]    sz;
        logic [3:0]    t;
        logic [MW-1:0] e;
        logic [IW-1:0] bts[W];
        int            n;

        bus.in_header     = '0;
        bus.in_header_v   = 1'b0;
        bus.in_data       = '0;
        bus.in_data_v     = 1'b0;
        bus.out_msg_ready = 1'b0;
        model             = '0;

        #12 rst = 1'b0;
        tick();
        chk("rst_out_v", MW'(bus.out_msg_v), MW'(0));
        chk("rst_hdr_rdy", MW'(bus.in_header_ready), MW'(1));
        chk("rst_data_rdy", MW'(bus.in_data_ready), MW'(1));

        // 64B write: eight beats 0..7
        h = mkhdr(T_WR, 3'd6);
        put_hdr(h);
        for (int i = 0; i < W; i++) begin
            chk("w64_early_v", MW'(bus.out_msg_v), MW'(0));
            put_beat(IW'(i), i);
        end
        chk("w64_v", MW'(bus.out_msg_v), MW'(1));
        chk("w64_msg", bus.out_msg, {h, model});
        tick();
        chk("w64_data_rdy", MW'(bus.in_data_ready), MW'(0));
        take();
        chk("w64_drained_v", MW'(bus.out_msg_v), MW'(0));
        chk("w64_data_rdy2", MW'(bus.in_data_ready), MW'(1));

        // 16B write with header and first beat in the same cycle
        h = mkhdr(T_WR, 3'd4);
        put_both(h, {$urandom, $urandom});
        chk("w16_mid_v", MW'(bus.out_msg_v), MW'(0));
        put_beat({$urandom, $urandom}, 1);
        chk("w16_v", MW'(bus.out_msg_v), MW'(1));
        chk("w16_msg", bus.out_msg, {h, model});
        take();

        // read: no data carried, SIPO untouched
        h = mkhdr(T_RD, 3'd6);
        put_hdr(h);
        chk("rd_v", MW'(bus.out_msg_v), MW'(1));
        chk("rd_msg", bus.out_msg, {h, model});
        chk("rd_data_rdy", MW'(bus.in_data_ready), MW'(1));
        take();
        chk("rd_drained_v", MW'(bus.out_msg_v), MW'(0));

        // backpressure: message held, second header refused until drain
        h = mkhdr(T_WR, 3'd6);
        put_hdr(h);
        for (int i = 0; i < W; i++) put_beat({$urandom, $urandom}, i);
        e  = {h, model};
        h2 = mkhdr(T_RD, 3'd2);
        bus.in_header   = h2;
        bus.in_header_v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_v", MW'(bus.out_msg_v), MW'(1));
            chk("stall_msg", bus.out_msg, e);
            chk("stall_hdr_rdy", MW'(bus.in_header_ready), MW'(0));
            tick();
        end
        take();
        chk("stall_hdr_rdy2", MW'(bus.in_header_ready), MW'(1));
        tick();
        bus.in_header_v = 1'b0;
        chk("stall_rd_v", MW'(bus.out_msg_v), MW'(1));
        chk("stall_rd_msg", bus.out_msg, {h2, model});
        take();

        // 1B write: less than one beat still needs one beat
        h = mkhdr(T_WR, 3'd0);
        put_hdr(h);
        put_beat({$urandom, $urandom}, 0);
        chk("w1_v", MW'(bus.out_msg_v), MW'(1));
        chk("w1_msg", bus.out_msg, {h, model});
        take();

        // asynchronous reset mid-burst
        h = mkhdr(T_WR, 3'd6);
        put_hdr(h);
        for (int i = 0; i < 3; i++) put_beat({$urandom, $urandom}, i);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_v", MW'(bus.out_msg_v), MW'(0));
        chk("arst_hdr_rdy", MW'(bus.in_header_ready), MW'(1));
        chk("arst_data_rdy", MW'(bus.in_data_ready), MW'(1));
        @(negedge clk);
        rst = 1'b0;
        tick();
        h = mkhdr(T_WR, 3'd6);
        put_hdr(h);
        for (int i = 0; i < W; i++) put_beat({$urandom, $urandom}, i);
        chk("arst_full_v", MW'(bus.out_msg_v), MW'(1));
        chk("arst_full_msg", bus.out_msg, {h, model});
        take();

        // randomized traffic with a concurrent consumer
        fork
            begin
                for (int k = 0; k < NRND; k++) begin
                    t  = 4'($urandom_range(0, 15));
                    sz = 3'($urandom_range(0, 6));
                    h  = mkhdr(t, sz);
                    n  = MASK[t] ? nbeats(sz) : 0;
                    for (int i = 0; i < n; i++) begin
                        bts[i]   = {$urandom, $urandom};
                        model[i] = bts[i];
                    end
                    expq.push_back({h, model});
                    put_hdr(h);
                    for (int i = 0; i < n; i++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        put_beat(bts[i], i);
                    end
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            begin
                int got, cyc;
                got = 0;
                cyc = 0;
                while (got < NRND && cyc < 20000) begin
                    bus.out_msg_ready = ($urandom_range(0, 3) != 0);
                    if (bus.out_msg_v && bus.out_msg_ready) begin
                        if (expq.size() == 0) chk("rnd_extra", MW'(0), MW'(1));
                        else chk("rnd_msg", bus.out_msg, expq.pop_front());
                        got++;
                    end
                    tick();
                    cyc++;
                end
                if (got < NRND) chk("rnd_timeout", MW'(got), MW'(NRND));
                bus.out_msg_ready = 1'b0;
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
